// File: rtl/poseidon_input_framer.sv
// Receive-side framer: packs ARITY field elements per valid/ready/last frame into one
// parallel state vector for the permutation core, discarding short and long frames.
module poseidon_input_framer #(
  parameter int unsigned WIDTH = 255,
  parameter int unsigned ARITY = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   io_input_valid,
  output logic                   io_input_ready,
  input  logic                   io_input_last,
  input  logic [WIDTH-1:0]       io_input_payload,
  output logic                   io_output_valid,
  input  logic                   io_output_ready,
  output logic [ARITY*WIDTH-1:0] io_output_payload,
  output logic                   io_frame_error,
  output logic [CNT_W-1:0]       io_frame_count
);

  localparam int unsigned IDX_W = (ARITY > 1) ? $clog2(ARITY) : 1;
  localparam int unsigned VEC_W = ARITY * WIDTH;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ARITY - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EMIT    = 2'd1,
    DROP    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VEC_W-1:0] buf_q, buf_d;
  logic [VEC_W-1:0] payload_q, payload_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = io_input_valid & in_ready_q;
  assign out_xfer = out_valid_q & io_output_ready;

  // Next-state: slot capture, frame-length policing, hand-off to the core
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    payload_d = payload_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;

    case (state_q)
      COLLECT: begin
        if (in_xfer) begin
          buf_d[idx_q*WIDTH +: WIDTH] = io_input_payload;
          if (io_input_last) begin
            idx_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d   = EMIT;
              payload_d = buf_d;
            end else begin
              err_d = 1'b1;
            end
          end else if (idx_q == IDX_LAST) begin
            err_d   = 1'b1;
            idx_d   = '0;
            state_d = DROP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      EMIT: begin
        if (out_xfer) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = COLLECT;
        end
      end
      DROP: begin
        if (in_xfer && io_input_last) begin
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
        idx_d   = '0;
      end
    endcase

    in_ready_d  = (state_d != EMIT);
    out_valid_d = (state_d == EMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= COLLECT;
      idx_q       <= '0;
      buf_q       <= '0;
      payload_q   <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      payload_q   <= payload_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign io_input_ready    = in_ready_q;
  assign io_output_valid   = out_valid_q;
  assign io_output_payload = payload_q;
  assign io_frame_error    = err_q;
  assign io_frame_count    = cnt_q;

endmodule

// File: tb/tb_poseidon_input_framer.sv
// Bench for poseidon_input_framer: directed vector table, hand sequences for corner
// cases, and randomized traffic checked every cycle against a queue-based frame model.
module tb_poseidon_input_framer;

  localparam int unsigned WIDTH = 255;
  localparam int unsigned ARITY = 3;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned VEC_W = ARITY * WIDTH;
  localparam int unsigned NV    = 11;

  logic             clk = 1'b0;
  logic             reset;
  logic             vld;
  logic             rdy_o;
  logic             lst;
  logic [WIDTH-1:0] pay;
  logic             ovld;
  logic             orr;
  logic [VEC_W-1:0] opay;
  logic             err;
  logic [CNT_W-1:0] cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int err_seen = 0;
  int hs_seen = 0;
  logic rnd = 1'b0;

  always #5 clk = ~clk;

  poseidon_input_framer #(.WIDTH(WIDTH), .ARITY(ARITY), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .io_input_valid    (vld),
    .io_input_ready    (rdy_o),
    .io_input_last     (lst),
    .io_input_payload  (pay),
    .io_output_valid   (ovld),
    .io_output_ready   (orr),
    .io_output_payload (opay),
    .io_frame_error    (err),
    .io_frame_count    (cnt)
  );

  task automatic check(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] word(input logic [7:0] x);
    return {7'h2A, {31{x}}};
  endfunction

  function automatic logic [VEC_W-1:0] pk3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic [WIDTH-1:0] c);
    return {c, b, a};
  endfunction

  // Reference model: words of the frame in progress kept in a queue
  logic [WIDTH-1:0] cur[$];
  logic             m_en = 1'b0;
  logic             m_drop = 1'b0;
  logic             m_pend = 1'b0;
  logic             m_err = 1'b0;
  logic             m_after_rst = 1'b0;
  logic [VEC_W-1:0] m_pay = '0;
  logic [CNT_W-1:0] m_cnt = '0;

  always @(posedge clk) begin : model
    logic rdy_now;
    cyc++;
    if (ovld && orr) hs_seen++;
    if (reset) begin
      cur.delete();
      m_en = 1'b1;
      m_drop = 1'b0;
      m_pend = 1'b0;
      m_err = 1'b0;
      m_after_rst = 1'b1;
      m_pay = '0;
      m_cnt = '0;
    end else if (m_en) begin
      rdy_now = !m_after_rst && !m_pend;
      m_err = 1'b0;
      if (m_pend && orr) begin
        m_pend = 1'b0;
        m_cnt = m_cnt + 1'b1;
      end else if (vld && rdy_now) begin
        if (m_drop) begin
          if (lst) m_drop = 1'b0;
        end else begin
          cur.push_back(pay);
          if (lst) begin
            if (cur.size() == int'(ARITY)) begin
              m_pend = 1'b1;
              for (int k = 0; k < int'(ARITY); k++) m_pay[k*WIDTH +: WIDTH] = cur[k];
            end else begin
              m_err = 1'b1;
            end
            cur.delete();
          end else if (cur.size() == int'(ARITY)) begin
            m_err = 1'b1;
            m_drop = 1'b1;
            cur.delete();
          end
        end
      end
      m_after_rst = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_en) begin
      if (err && !reset) err_seen++;
      check("m_in_ready", VEC_W'(rdy_o), VEC_W'(!m_after_rst && !m_pend));
      check("m_out_valid", VEC_W'(ovld), VEC_W'(m_pend));
      check("m_payload", opay, m_pay);
      check("m_frame_error", VEC_W'(err), VEC_W'(m_err));
      check("m_frame_count", VEC_W'(cnt), VEC_W'(m_cnt));
    end
  end

  typedef struct {
    logic             v;
    logic             l;
    logic [WIDTH-1:0] w;
    logic             orr;
    logic             e_rdy;
    logic             e_ov;
    logic             e_err;
    logic [CNT_W-1:0] e_cnt;
    logic [VEC_W-1:0] e_pay;
  } vec_t;

  vec_t vec [NV];

  function automatic vec_t mkv(input logic v, input logic l, input logic [WIDTH-1:0] w, input logic o,
                               input logic e_rdy, input logic e_ov, input logic e_err,
                               input logic [CNT_W-1:0] e_cnt, input logic [VEC_W-1:0] e_pay);
    vec_t r;
    r.v = v; r.l = l; r.w = w; r.orr = o;
    r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_err = e_err; r.e_cnt = e_cnt; r.e_pay = e_pay;
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      vld = 1'b0;
      if (rnd) orr = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge
  task automatic send(input logic [WIDTH-1:0] w, input logic l);
    int guard;
    guard = 0;
    vld = 1'b1;
    lst = l;
    pay = w;
    if (rnd) orr = 1'($urandom_range(0, 1));
    while (!rdy_o) begin
      @(negedge clk);
      if (rnd) orr = 1'($urandom_range(0, 1));
      guard++;
      if (guard > 200) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: got ready=0 expected ready=1 within 200 cycles");
        break;
      end
    end
    @(negedge clk);
    vld = 1'b0;
    lst = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] rword();
    logic [255:0] t;
    for (int k = 0; k < 8; k++) t[k*32 +: 32] = $urandom();
    return t[WIDTH-1:0];
  endfunction

  initial begin
    #2_000_000;
    tests++;
    fails++;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic [WIDTH-1:0] ref_w;
    int c0;
    int e0;
    int h0;
    int len;
    int r;

    ref_w = {16'h5f6d, 223'(64'h0123_4567_89ab_cdef), 16'h4c5f};

    vec[0]  = mkv(1'b0, 1'b0, '0,          1'b0, 1'b1, 1'b0, 1'b0, 8'd0, '0);
    vec[1]  = mkv(1'b1, 1'b0, word(8'hA1), 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, '0);
    vec[2]  = mkv(1'b1, 1'b0, word(8'hB2), 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, '0);
    vec[3]  = mkv(1'b1, 1'b1, word(8'hC3), 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,
                  pk3(word(8'hA1), word(8'hB2), word(8'hC3)));
    vec[4]  = mkv(1'b0, 1'b0, '0,          1'b1, 1'b1, 1'b0, 1'b0, 8'd1,
                  pk3(word(8'hA1), word(8'hB2), word(8'hC3)));
    vec[5]  = mkv(1'b1, 1'b0, word(8'h11), 1'b1, 1'b1, 1'b0, 1'b0, 8'd1,
                  pk3(word(8'hA1), word(8'hB2), word(8'hC3)));
    vec[6]  = mkv(1'b1, 1'b1, word(8'h22), 1'b1, 1'b1, 1'b0, 1'b1, 8'd1,
                  pk3(word(8'hA1), word(8'hB2), word(8'hC3)));
    vec[7]  = mkv(1'b1, 1'b0, word(8'hD4), 1'b1, 1'b1, 1'b0, 1'b0, 8'd1,
                  pk3(word(8'hA1), word(8'hB2), word(8'hC3)));
    vec[8]  = mkv(1'b1, 1'b0, word(8'hE5), 1'b1, 1'b1, 1'b0, 1'b0, 8'd1,
                  pk3(word(8'hA1), word(8'hB2), word(8'hC3)));
    vec[9]  = mkv(1'b1, 1'b1, word(8'hF6), 1'b0, 1'b0, 1'b1, 1'b0, 8'd1,
                  pk3(word(8'hD4), word(8'hE5), word(8'hF6)));
    vec[10] = mkv(1'b0, 1'b0, '0,          1'b1, 1'b1, 1'b0, 1'b0, 8'd2,
                  pk3(word(8'hD4), word(8'hE5), word(8'hF6)));

    reset = 1'b1;
    vld = 1'b0;
    lst = 1'b0;
    pay = '0;
    orr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", VEC_W'(rdy_o), '0);
    check("rst_out_valid", VEC_W'(ovld), '0);
    check("rst_payload", opay, '0);
    check("rst_frame_error", VEC_W'(err), '0);
    check("rst_frame_count", VEC_W'(cnt), '0);
    reset = 1'b0;

    // Good frame, short frame, good frame
    for (int i = 0; i < int'(NV); i++) begin
      vld = vec[i].v;
      lst = vec[i].l;
      pay = vec[i].w;
      orr = vec[i].orr;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_in_ready", i), VEC_W'(rdy_o), VEC_W'(vec[i].e_rdy));
      check($sformatf("vec%0d_out_valid", i), VEC_W'(ovld), VEC_W'(vec[i].e_ov));
      check($sformatf("vec%0d_frame_error", i), VEC_W'(err), VEC_W'(vec[i].e_err));
      check($sformatf("vec%0d_frame_count", i), VEC_W'(cnt), VEC_W'(vec[i].e_cnt));
      check($sformatf("vec%0d_payload", i), opay, vec[i].e_pay);
      @(negedge clk);
    end
    vld = 1'b0;
    orr = 1'b1;

    // 100 back-to-back frames of the reference word
    c0 = cyc;
    e0 = err_seen;
    h0 = hs_seen;
    for (int f = 0; f < 100; f++) begin
      send(ref_w, 1'b0);
      send(ref_w, 1'b0);
      send(ref_w, 1'b1);
    end
    check("b2b_cycles", VEC_W'(cyc - c0), VEC_W'(399));
    idle(1);
    check("b2b_outputs", VEC_W'(hs_seen - h0), VEC_W'(100));
    check("b2b_errors", VEC_W'(err_seen - e0), '0);
    check("b2b_count", VEC_W'(cnt), VEC_W'(8'd102));
    check("b2b_payload", opay, pk3(ref_w, ref_w, ref_w));

    // Long frame of five words, then a good frame
    e0 = err_seen;
    for (int j = 0; j < 5; j++) send(word(8'h30 + 8'(j)), j == 4);
    send(word(8'h41), 1'b0);
    send(word(8'h42), 1'b0);
    send(word(8'h43), 1'b1);
    idle(2);
    check("long_errors", VEC_W'(err_seen - e0), VEC_W'(1));
    check("long_count", VEC_W'(cnt), VEC_W'(8'd103));
    check("long_payload", opay, pk3(word(8'h41), word(8'h42), word(8'h43)));

    // Core stalls for 10 cycles while the source keeps offering a word
    orr = 1'b0;
    send(word(8'h51), 1'b0);
    send(word(8'h52), 1'b0);
    send(word(8'h53), 1'b1);
    vld = 1'b1;
    pay = word(8'h61);
    lst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      check("stall_in_ready", VEC_W'(rdy_o), '0);
      check("stall_out_valid", VEC_W'(ovld), VEC_W'(1));
      check("stall_payload", opay, pk3(word(8'h51), word(8'h52), word(8'h53)));
      @(negedge clk);
    end
    orr = 1'b1;
    send(word(8'h61), 1'b0);
    send(word(8'h62), 1'b0);
    send(word(8'h63), 1'b1);
    idle(2);
    check("stall_count", VEC_W'(cnt), VEC_W'(8'd105));
    check("stall_payload2", opay, pk3(word(8'h61), word(8'h62), word(8'h63)));

    // Reset in the middle of a frame
    e0 = err_seen;
    send(word(8'h71), 1'b0);
    send(word(8'h72), 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_in_ready", VEC_W'(rdy_o), '0);
    check("midrst_out_valid", VEC_W'(ovld), '0);
    check("midrst_payload", opay, '0);
    check("midrst_count", VEC_W'(cnt), '0);
    reset = 1'b0;
    send(word(8'h81), 1'b0);
    send(word(8'h82), 1'b0);
    send(word(8'h83), 1'b1);
    idle(2);
    check("midrst_errors", VEC_W'(err_seen - e0), '0);
    check("midrst_count2", VEC_W'(cnt), VEC_W'(8'd1));
    check("midrst_payload2", opay, pk3(word(8'h81), word(8'h82), word(8'h83)));

    // Counter wrap at 2^CNT_W
    for (int f = 0; f < 254; f++) begin
      send(ref_w, 1'b0);
      send(ref_w, 1'b0);
      send(ref_w, 1'b1);
    end
    idle(1);
    check("wrap_count_max", VEC_W'(cnt), VEC_W'(8'hFF));
    send(ref_w, 1'b0);
    send(ref_w, 1'b0);
    send(ref_w, 1'b1);
    idle(1);
    check("wrap_count_zero", VEC_W'(cnt), '0);

    // Random traffic: mixed frame lengths, gaps and core back-pressure
    rnd = 1'b1;
    for (int f = 0; f < 150; f++) begin
      r = $urandom_range(0, 9);
      len = (r < 6) ? 3 : (r == 6) ? 1 : (r == 7) ? 2 : (r == 8) ? 4 : 5;
      for (int j = 0; j < len; j++) begin
        idle($urandom_range(0, 2));
        send(rword(), j == len - 1);
      end
    end
    rnd = 1'b0;
    orr = 1'b1;
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
